// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with parallel load, a registered Gray-code view of the
// same count, and a one-cycle wrap pulse. Every output comes straight from a flop.
module bin_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] binIn,
  output logic [WIDTH-1:0] binOut,
  output logic [WIDTH-1:0] grayOut,
  output logic             wrap,
  output logic             valid
);

  logic [WIDTH-1:0] nextBin;
  logic [WIDTH-1:0] nextGray;
  logic             nextWrap;

  // Priority below reset: load, then count, then hold.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    nextBin  = binOut;
    nextWrap = 1'b0;
    if (load) begin
      nextBin = binIn;
    end else if (en) begin
      if (up) begin
        nextBin  = binOut + 1'b1;
        nextWrap = &binOut;
      end else begin
        nextBin  = binOut - 1'b1;
        nextWrap = ~|binOut;
      end
    end
  end

  // Gray is derived from the next count so both views change on the same edge.
  assign nextGray = nextBin ^ (nextBin >> 1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      binOut  <= '0;
      grayOut <= '0;
      wrap    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      binOut  <= nextBin;
      grayOut <= nextGray;
      wrap    <= nextWrap;
      valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench: an integer-arithmetic reference model checked every cycle,
// directed scenarios pinned by hand-computed literals, then randomized traffic.
module tb_bin_to_gray_counter;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] binIn;
  logic [W-1:0] binOut, grayOut;
  logic         wrap, valid;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  int  mBin;
  bit  mWrap, mValid;
  bit  started = 1'b0;
  bit  countedStep;
  logic [W-1:0] prevGray;

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .load   (load),
    .binIn  (binIn),
    .binOut (binOut),
    .grayOut(grayOut),
    .wrap   (wrap),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int toGray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Model update on every edge, then compare once outputs have settled.
  always @(posedge clk) begin
    int n;
    prevGray    = grayOut;
    countedStep = started && !rst && !load && en;
    if (rst) begin
      mBin = 0; mWrap = 0; mValid = 0; started = 1'b1;
    end else if (started) begin
      mWrap  = 0;
      mValid = 1;
      if (load) begin
        mBin = int'(binIn);
      end else if (en) begin
        n     = up ? mBin + 1 : mBin - 1;
        mWrap = (n < 0) || (n >= MODV);
        mBin  = (n + MODV) % MODV;
      end
    end
    #1;
    if (started) begin
      check("binOut",  32'(binOut),  32'(mBin));
      check("grayOut", 32'(grayOut), 32'(toGray(mBin)));
      check("wrap",    32'(wrap),    32'(mWrap));
      check("valid",   32'(valid),   32'(mValid));
      if (countedStep)
        check("grayOneBit", 32'($countones(grayOut ^ prevGray)), 32'd1);
    end
  end

  task automatic step(input bit r, input bit l, input bit e, input bit u, input logic [W-1:0] b);
    @(negedge clk);
    rst = r; load = l; en = e; up = u; binIn = b;
    @(posedge clk);
    #2;
  endtask

  task automatic expect3(input string name, input logic [W-1:0] eb, input logic [W-1:0] eg,
                         input bit ew);
    check({name, ".bin"},  32'(binOut),  32'(eb));
    check({name, ".gray"}, 32'(grayOut), 32'(eg));
    check({name, ".wrap"}, 32'(wrap),    32'(ew));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] grayTbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                   4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};
    rst = 1; load = 0; en = 0; up = 0; binIn = '0;
    step(1, 0, 1, 1, 4'hF);
    step(1, 1, 1, 1, 4'hF);
    expect3("reset", 4'b0000, 4'b0000, 0);
    check("reset.valid", 32'(valid), 32'd0);

    // Full up-count sequence and wrap
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 1, 1, '0);
      check("seq.gray", 32'(grayOut), 32'(grayTbl[i]));
    end
    check("seq.valid", 32'(valid), 32'd1);
    step(0, 0, 1, 1, '0);
    expect3("seqWrap", 4'b0000, 4'b0000, 1);
    step(0, 0, 0, 1, '0);
    check("seqWrapDrop", 32'(wrap), 32'd0);

    // Load then count
    step(0, 1, 0, 0, 4'b1010);
    expect3("load", 4'b1010, 4'b1111, 0);
    step(0, 0, 1, 1, '0);
    expect3("loadCount", 4'b1011, 4'b1110, 0);

    // Down-count wrap from zero
    step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 1, 0, '0);
    expect3("downWrap", 4'b1111, 4'b1000, 1);
    step(0, 0, 1, 0, '0);
    expect3("downNext", 4'b1110, 4'b1001, 0);

    // Load beats count, no wrap at all-ones
    step(0, 1, 0, 0, 4'b1111);
    step(0, 1, 1, 1, 4'b0111);
    expect3("loadBeatsCount", 4'b0111, 4'b0100, 0);

    // Hold
    step(0, 1, 0, 0, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 4'hA);
      expect3("hold", 4'b0101, 4'b0111, 0);
    end

    // Reset mid-count, then immediate count after release
    step(0, 1, 0, 0, 4'b1001);
    step(1, 0, 1, 1, '0);
    expect3("midReset", 4'b0000, 4'b0000, 0);
    check("midReset.valid", 32'(valid), 32'd0);
    step(0, 0, 1, 1, '0);
    expect3("postReset", 4'b0001, 4'b0001, 0);
    check("postReset.valid", 32'(valid), 32'd1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
           1'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
